// File: rtl/btn_cond_pkg.sv
// Shared types and defaults for the push-button conditioner.
// Debouncer state codes are Gray-ordered so that the level is simply bit 1.
package btn_cond_pkg;

    localparam int DEBOUNCE_CYCLES_DEF = 500000;
    localparam int CNT_W_DEF           = 20;

    typedef enum logic [1:0] {
        S_LOW  = 2'b00,
        S_RISE = 2'b01,
        S_HIGH = 2'b11,
        S_FALL = 2'b10
    } db_state_e;

    function automatic logic level_of(input db_state_e st);
        return st[1];
    endfunction

endpackage

// File: rtl/btn_cond_if.sv
// Bundle of the conditioner's control inputs, raw buttons and clean outputs.
interface btn_cond_if;
    logic enable;
    logic tick;
    logic ini_raw;
    logic up_raw;
    logic ini;
    logic up;

    modport master (output enable, output tick, output ini_raw, output up_raw,
                    input ini, input up);
    modport slave  (input enable, input tick, input ini_raw, input up_raw,
                    output ini, output up);
endinterface

// File: rtl/btn_cond_debounce_fsm.sv
// Two-flop synchroniser followed by a four-state debouncer with a stability window.
// Outputs are next-state decodes so the parent register adds no extra latency.
module btn_cond_debounce_fsm
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    input  logic enable,
    input  logic raw,
    output logic level_next,
    output logic rise
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic             s1_r;
    logic             s2_r;
    db_state_e        state_r;
    db_state_e        state_next_s;
    logic [CNT_W-1:0] cnt_r;
    logic [CNT_W-1:0] cnt_next_s;
    logic             rise_s;

    // Synchroniser runs regardless of enable; it only guards against metastability.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            s1_r <= 1'b0;
            s2_r <= 1'b0;
        end else begin
            s1_r <= raw;
            s2_r <= s1_r;
        end
    end

    // Debouncer state and window counter.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= S_LOW;
            cnt_r   <= CNT_ZERO;
        end else begin
            state_r <= state_next_s;
            cnt_r   <= cnt_next_s;
        end
    end

    // Next-state logic: a bounce inside a window restarts it from zero.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        rise_s       = 1'b0;
        if (enable) begin
            case (state_r)
                S_LOW: begin
                    if (s2_r) begin
                        state_next_s = S_RISE;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        state_next_s = S_LOW;
                    end
                end
                S_RISE: begin
                    if (!s2_r) begin
                        state_next_s = S_LOW;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_next_s = S_HIGH;
                        rise_s       = 1'b1;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                S_HIGH: begin
                    if (!s2_r) begin
                        state_next_s = S_FALL;
                        cnt_next_s   = CNT_ZERO;
                    end else begin
                        state_next_s = S_HIGH;
                    end
                end
                S_FALL: begin
                    if (s2_r) begin
                        state_next_s = S_HIGH;
                        cnt_next_s   = CNT_ZERO;
                    end else if (cnt_r == CNT_LAST) begin
                        state_next_s = S_LOW;
                    end else begin
                        cnt_next_s   = cnt_r + CNT_ONE;
                    end
                end
                default: begin
                    state_next_s = S_LOW;
                    cnt_next_s   = CNT_ZERO;
                end
            endcase
        end else begin
            state_next_s = state_r;
            cnt_next_s   = cnt_r;
        end
    end

    assign level_next = level_of(state_next_s);
    assign rise       = rise_s;

endmodule

// File: rtl/btn_cond.sv
// Button conditioner: debounced up level, and ini as a press event held pending
// until the next slow-clock tick so the strobe-enabled state register cannot miss it.
module btn_cond
    import btn_cond_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int CNT_W           = CNT_W_DEF
) (
    input  logic clock,
    input  logic reset,
    btn_cond_if.slave bus
);

    logic ini_level_next_s;
    logic ini_rise_s;
    logic up_level_next_s;
    logic up_rise_s;
    logic ini_r;
    logic up_r;

    btn_cond_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_ini (
        .clock      (clock),
        .reset      (reset),
        .enable     (bus.enable),
        .raw        (bus.ini_raw),
        .level_next (ini_level_next_s),
        .rise       (ini_rise_s)
    );

    btn_cond_debounce_fsm #(
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
        .CNT_W           (CNT_W)
    ) u_db_up (
        .clock      (clock),
        .reset      (reset),
        .enable     (bus.enable),
        .raw        (bus.up_raw),
        .level_next (up_level_next_s),
        .rise       (up_rise_s)
    );

    // A new commit wins over a simultaneous tick; ticks are ignored while frozen.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            ini_r <= 1'b0;
            up_r  <= 1'b0;
        end else if (bus.enable) begin
            ini_r <= ini_rise_s | (ini_r & ~bus.tick);
            up_r  <= up_level_next_s;
        end else begin
            ini_r <= ini_r;
            up_r  <= up_r;
        end
    end

    assign bus.ini = ini_r;
    assign bus.up  = up_r;

endmodule

// File: tb/tb_btn_cond.sv
// Scoreboard bench for btn_cond with a 4-cycle debounce window (7-edge latency).
module tb_btn_cond;

    logic clock;
    logic reset;
    int   n_checks;
    int   n_pass;
    logic [1:0] exp_q[$];

    btn_cond_if bus ();

    btn_cond #(
        .DEBOUNCE_CYCLES (4),
        .CNT_W           (3)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        n_checks++;
        if (obs === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %0b expected %0b at %0t", tag, obs, exp, $time);
        end
    endtask

    // Drive one cycle of stimulus, queue the expectation, compare after the edge.
    task automatic run_step(input string tag, input logic en, input logic tk,
                            input logic ir, input logic ur,
                            input logic e_ini, input logic e_up);
        logic [1:0] e;
        @(negedge clock);
        bus.enable  = en;
        bus.tick    = tk;
        bus.ini_raw = ir;
        bus.up_raw  = ur;
        exp_q.push_back({e_ini, e_up});
        @(posedge clock);
        #1;
        e = exp_q.pop_front();
        check_bit({tag, ".ini"}, bus.ini, e[1]);
        check_bit({tag, ".up"},  bus.up,  e[0]);
    endtask

    initial begin
        n_checks    = 0;
        n_pass      = 0;
        reset       = 1'b0;
        bus.enable  = 1'b1;
        bus.tick    = 1'b0;
        bus.ini_raw = 1'b1;
        bus.up_raw  = 1'b1;

        // 1: reset with buttons held, then both commit 7 edges after release
        for (int t = 0; t < 3; t++) run_step("rst_hold", 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0);
        reset = 1'b1;
        for (int t = 0; t < 11; t++)
            run_step("rst_rel", 1'b1, (t == 10), 1'b1, 1'b1, (t >= 6 && t < 10), (t >= 6));
        for (int t = 0; t < 10; t++)
            run_step("rst_fall", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (t < 6));

        // 2: bounce 1,0,1,0 then steady high
        for (int t = 0; t < 14; t++)
            run_step("bounce", 1'b1, 1'b0, 1'b0, (t == 0 || t == 2 || t >= 4), 1'b0, (t >= 10));
        for (int t = 0; t < 8; t++)
            run_step("bounce_rel", 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, (t < 6));

        // 3: three-cycle glitch never commits
        for (int t = 0; t < 12; t++)
            run_step("glitch", 1'b1, 1'b0, 1'b0, (t < 3), 1'b0, 1'b0);

        // 4: ini pending from commit until the tick 20 cycles later; early release
        for (int t = 0; t < 31; t++)
            run_step("pend", 1'b1, (t == 26), (t < 10), 1'b0, (t >= 6 && t < 26), 1'b0);

        // 5: commit coincides with tick, so ini survives until the following tick
        for (int t = 0; t < 21; t++)
            run_step("simul", 1'b1, (t == 6 || t == 12), (t < 8), 1'b0, (t >= 6 && t < 12), 1'b0);

        // 6: freeze mid-window for 10 cycles with ticks; ini held, up delayed by 10
        for (int t = 0; t < 26; t++)
            run_step("freeze", !(t >= 7 && t <= 16),
                     (t == 8 || t == 12 || t == 16 || t == 22),
                     1'b1, (t >= 2), (t >= 6 && t < 22), (t >= 18));

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
